// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for a core load/store path. Accepts one
//            request at a time on a valid/ready request channel, services it
//            against an internal 64-bit word RAM, and returns read data or a
//            write acknowledgement on a valid/ready response channel after a
//            programmable latency.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            req_valid/req_ready         - request handshake (req_ready registered)
//            req_wen, req_addr           - 1 = write; byte address (8-byte aligned)
//            req_wdata, req_wmask        - write data and byte enables
//            resp_valid/resp_ready       - response handshake
//            resp_rdata, resp_err        - read data (0 for writes/errors), error
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [3:0]  LAT   = 4'(LATENCY);
    // One past the last valid byte address, held in 65 bits so a BASE near the
    // top of the address space cannot wrap.
    localparam logic [64:0] LIMIT = {1'b0, BASE} + (65'(DEPTH) << 3);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic [63:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        a_wen;
    logic [63:0] a_addr;
    logic [63:0] a_wdata;
    logic [7:0]  a_wmask;
    logic [64:0] a_off;
    logic [AW-1:0] idx;
    logic        err;
    logic        do_write;
    logic        unused_off_bits;

    assign accept = (state == S_IDLE) && req_valid && req_ready;

    // With zero latency the access happens on the accept edge itself, so the
    // access operands come straight from the request inputs in IDLE and from
    // the captured copy otherwise.
    assign enter_resp = (accept && (LAT == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));
    assign a_wen   = (state == S_IDLE) ? req_wen   : wen_q;
    assign a_addr  = (state == S_IDLE) ? req_addr  : addr_q;
    assign a_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
    assign a_wmask = (state == S_IDLE) ? req_wmask : wmask_q;

    assign a_off = {1'b0, a_addr} - {1'b0, BASE};
    assign idx   = a_off[AW+2:3];
    assign unused_off_bits = ^{a_off[64:AW+3], a_off[2:0]};

    assign err = (a_addr[2:0] != 3'd0)
               || ({1'b0, a_addr} <  {1'b0, BASE})
               || ({1'b0, a_addr} >= LIMIT);

    assign do_write = enter_resp && a_wen && !err;

    assign resp_valid = (state == S_RESP);

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (a_wmask[b]) begin
                    mem[idx][b*8 +: 8] <= a_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        wen_q     <= req_wen;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        cnt       <= LAT;
                        req_ready <= 1'b0;
                        state     <= (LAT == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase

            // Response payload is latched on the edge that enters RESP and held
            // there until the response handshake.
            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || a_wen) ? 64'd0 : mem[idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder. One instance uses
//            LATENCY=2, a second uses LATENCY=0 for back-to-back timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_wen;
    logic [63:0] z_req_addr, z_req_wdata;
    logic [7:0]  z_req_wmask;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [63:0] z_resp_rdata;

    int checks;
    int failures;

    mem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    mem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_wen    (z_req_wen),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_wmask  (z_req_wmask),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance. Starts and ends at a negedge.
    // hold = number of cycles resp_ready is held low once the response is up.
    task automatic xact(input string tag, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = wmask;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, "_hold_err"}, 64'(resp_err), 64'(exp_err));
            check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_done_req_ready"}, 64'(req_ready), 64'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        req_wmask    = 8'd0;
        resp_ready   = 1'b0;
        z_req_valid  = 1'b0;
        z_req_wen    = 1'b0;
        z_req_addr   = 64'd0;
        z_req_wdata  = 64'd0;
        z_req_wmask  = 8'd0;
        z_resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_z_req_ready", 64'(z_req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready_pre_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready), 64'd1);
        check("rel_z_req_ready", 64'(z_req_ready), 64'd1);

        // Full write, partial write, read-back of merged word
        xact("wr_full", 1'b1, BASE, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0, 0);
        xact("wr_part", 1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0, 1'b0, 0);
        xact("rd_part", 1'b0, BASE, 64'd0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0, 0);

        // Last word, then error cases, then confirm RAM untouched
        xact("wr_top", 1'b1, 64'h8000_1FF8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 64'd0, 1'b0, 0);
        xact("err_misaligned", 1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'd0, 1'b1, 0);
        xact("err_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1, 0);
        xact("err_past_end", 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0, 1'b1, 0);
        xact("rd_top", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0);
        xact("rd_word0", 1'b0, BASE, 64'd0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0, 0);
        xact("wr_mask0", 1'b1, BASE, 64'h0, 8'h00, 64'd0, 1'b0, 0);
        xact("rd_after_mask0", 1'b0, BASE, 64'd0, 8'h00, 64'h1122_3344_FFFF_FFFF, 1'b0, 0);

        // Backpressure: response held 5 cycles
        xact("backpressure", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 5);

        // LATENCY=0 instance: write then back-to-back reads every 2 cycles
        z_req_valid  = 1'b1;
        z_req_wen    = 1'b1;
        z_req_addr   = BASE + 64'd8;
        z_req_wdata  = 64'h0123_4567_89AB_CDEF;
        z_req_wmask  = 8'hFF;
        z_resp_ready = 1'b1;
        check("lat0_pre_ready", 64'(z_req_ready), 64'd1);
        @(negedge clk);
        check("lat0_wr_valid", 64'(z_resp_valid), 64'd1);
        check("lat0_wr_rdata", z_resp_rdata, 64'd0);
        check("lat0_wr_err", 64'(z_resp_err), 64'd0);
        check("lat0_wr_req_ready", 64'(z_req_ready), 64'd0);
        z_req_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat0_gap_valid", 64'(z_resp_valid), 64'd0);
            check("lat0_gap_req_ready", 64'(z_req_ready), 64'd1);
            @(negedge clk);
            check("lat0_rd_valid", 64'(z_resp_valid), 64'd1);
            check("lat0_rd_rdata", z_resp_rdata, 64'h0123_4567_89AB_CDEF);
        end
        z_req_valid = 1'b0;
        @(negedge clk);
        check("lat0_end_valid", 64'(z_resp_valid), 64'd0);

        // Reset during WAIT drops a pending write
        xact("wr_pre10", 1'b1, 64'h8000_0010, 64'h5555_6666_7777_8888, 8'hFF, 64'd0, 1'b0, 0);
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_addr   = 64'h8000_0010;
        req_wdata  = 64'hAAAA_BBBB_CCCC_DDDD;
        req_wmask  = 8'hFF;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("midwait_req_ready", 64'(req_ready), 64'd0);
        check("midwait_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_valid", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midwait_no_resp", 64'(resp_valid), 64'd0);
        end
        resp_ready = 1'b0;
        xact("rd_post10", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h5555_6666_7777_8888, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
